// File: rtl/frame_gate_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frame_gate_pkg
//  Purpose  : Shared types and constants for the frame gate controller.
//             - state_e      : control FSM states
//             - ERR_LINE_*   : bit positions inside err_status
//             - cnt_width()  : width of the geometry counters
//  Revision : 1.0  initial release
// ============================================================================
package frame_gate_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam int ERR_LINE_LEN = 0;
  localparam int ERR_LINE_CNT = 1;

  // One bit of headroom above the larger dimension so a too-long line or
  // frame is still distinguishable from the expected value before saturating.
  function automatic int cnt_width(input int hdisp, input int vdisp);
    int m;
    m = (hdisp > vdisp) ? hdisp : vdisp;
    return $clog2(m) + 1;
  endfunction

endpackage : frame_gate_pkg
`default_nettype wire

// File: rtl/frame_geom_checker.sv
`default_nettype none
// ============================================================================
//  Module   : frame_geom_checker
//  Purpose  : Counts pixels per line and lines per frame while enabled and
//             reports geometry errors against IMG_HDISP x IMG_VDISP.
//  Ports    : clk, rst_n          clock, synchronous active-low reset
//             enable             count only while the frame is captured
//             clear              zero counters and sticky flags (frame entry)
//             href/clken/vsync   raw source stream qualifiers
//             err[1:0]           sticky flags merged with this cycle's checks;
//                                valid on the vsync falling-edge cycle
//  Revision : 1.0  initial release
// ============================================================================
module frame_geom_checker
  import frame_gate_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic       href,
  input  logic       clken,
  input  logic       vsync,
  output logic [1:0] err
);

  localparam int              CNT_W   = cnt_width(IMG_HDISP, IMG_VDISP);
  localparam logic [CNT_W-1:0] C_HDISP = CNT_W'(IMG_HDISP);
  localparam logic [CNT_W-1:0] C_VDISP = CNT_W'(IMG_VDISP);

  logic             href_d_q, vs_d_q;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [1:0]       flags_q, flags_d;

  logic             href_fall, vs_fall;
  logic             line_len_bad, line_cnt_bad;
  logic [CNT_W-1:0] line_cnt_inc;

  always_comb begin
    href_fall = ~href & href_d_q;
    vs_fall   = ~vsync & vs_d_q;

    // Line count including a line that ends this very cycle, so a line whose
    // href drops together with vsync is counted before the frame check.
    line_cnt_inc = line_cnt_q;
    if (href_fall && (line_cnt_q != '1)) line_cnt_inc = line_cnt_q + 1'b1;

    line_len_bad = href_fall & (pix_cnt_q != C_HDISP);
    line_cnt_bad = vs_fall & (line_cnt_inc != C_VDISP);

    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    flags_d    = flags_q;

    if (clear) begin
      pix_cnt_d  = '0;
      line_cnt_d = '0;
      flags_d    = 2'b00;
    end else if (enable) begin
      if (href_fall) begin
        pix_cnt_d = '0;
      end else if (href && clken && (pix_cnt_q != '1)) begin
        pix_cnt_d = pix_cnt_q + 1'b1;
      end
      line_cnt_d             = line_cnt_inc;
      flags_d[ERR_LINE_LEN]  = flags_q[ERR_LINE_LEN] | line_len_bad;
      flags_d[ERR_LINE_CNT]  = flags_q[ERR_LINE_CNT] | line_cnt_bad;
    end

    err               = flags_q;
    err[ERR_LINE_LEN] = flags_q[ERR_LINE_LEN] | line_len_bad;
    err[ERR_LINE_CNT] = flags_q[ERR_LINE_CNT] | line_cnt_bad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      href_d_q   <= 1'b0;
      vs_d_q     <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      flags_q    <= 2'b00;
    end else begin
      href_d_q   <= href;
      vs_d_q     <= vsync;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      flags_q    <= flags_d;
    end
  end

endmodule : frame_geom_checker
`default_nettype wire

// File: rtl/frame_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : frame_gate_ctrl
//  Purpose  : Command-driven frame gate between a pixel source and the
//             processing pipeline. Passes only whole, selected frames with a
//             fixed one-cycle latency and checks their geometry.
//  Ports    : clk, rst_n                  clock, synchronous active-low reset
//             cmd_start / cmd_stop        one-cycle command pulses
//             cfg_single, cfg_skip[3:0]   capture mode and decimation
//             in_vsync/href/clken/data    source stream
//             out_vsync/href/clken/data   gated, registered stream
//             busy                        controller not idle
//             frame_done, frame_err       end-of-captured-frame pulses
//             err_status[1:0]             last captured frame's geometry
//             frame_cnt[15:0]             captured frames, wrapping
//  Revision : 1.0  initial release
// ============================================================================
module frame_gate_ctrl
  import frame_gate_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int DATA_W    = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              cfg_single,
  input  logic [3:0]        cfg_skip,
  input  logic              in_vsync,
  input  logic              in_href,
  input  logic              in_clken,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vsync,
  output logic              out_href,
  output logic              out_clken,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_status,
  output logic [15:0]       frame_cnt
);

  state_e            state_q, state_d;
  logic [3:0]        skip_q, skip_d;
  logic              single_q, single_d;
  logic              stop_pend_q, stop_pend_d;
  logic              vs_d_q;

  logic              out_vsync_q, out_href_q, out_clken_q;
  logic [DATA_W-1:0] out_data_q;
  logic              frame_done_q, frame_err_q;
  logic [1:0]        err_status_q;
  logic [15:0]       frame_cnt_q;

  logic              vs_rise, vs_fall;
  logic              pass, enter_active, frame_end;
  logic [1:0]        geom_err;

  always_comb begin
    vs_rise      = in_vsync & ~vs_d_q;
    vs_fall      = ~in_vsync & vs_d_q;

    state_d      = state_q;
    skip_d       = skip_q;
    single_d     = single_q;
    stop_pend_d  = stop_pend_q;
    enter_active = 1'b0;
    frame_end    = 1'b0;

    case (state_q)
      IDLE: begin
        // Stop wins over a simultaneous start.
        if (cmd_start && !cmd_stop) begin
          skip_d   = cfg_skip;
          single_d = cfg_single;
          state_d  = ARM;
        end
      end
      ARM: begin
        // Only a rising vsync starts a capture, so a frame already in
        // flight when the block was armed is never taken.
        if (cmd_stop) begin
          state_d = IDLE;
        end else if (vs_rise) begin
          if (skip_q == 4'd0) begin
            state_d      = ACTIVE;
            enter_active = 1'b1;
          end else begin
            skip_d = skip_q - 4'd1;
          end
        end
      end
      ACTIVE: begin
        if (cmd_stop) stop_pend_d = 1'b1;
        if (vs_fall) begin
          frame_end   = 1'b1;
          stop_pend_d = 1'b0;
          if (single_q || stop_pend_q || cmd_stop) begin
            state_d = IDLE;
          end else begin
            state_d = ARM;
            skip_d  = cfg_skip;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Open the gate on the vsync-rise cycle itself so the captured frame's
    // vsync-high window reaches downstream complete.
    pass = (state_q == ACTIVE) | ((state_q == ARM) & vs_rise & (skip_q == 4'd0));
  end

  frame_geom_checker #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP)
  ) u_geom (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state_q == ACTIVE),
    .clear  (enter_active),
    .href   (in_href),
    .clken  (in_clken),
    .vsync  (in_vsync),
    .err    (geom_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      skip_q       <= 4'd0;
      single_q     <= 1'b0;
      stop_pend_q  <= 1'b0;
      vs_d_q       <= 1'b0;
      out_vsync_q  <= 1'b0;
      out_href_q   <= 1'b0;
      out_clken_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_status_q <= 2'b00;
      frame_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      single_q     <= single_d;
      stop_pend_q  <= stop_pend_d;
      vs_d_q       <= in_vsync;
      out_vsync_q  <= pass & in_vsync;
      out_href_q   <= pass & in_href;
      out_clken_q  <= pass & in_clken;
      out_data_q   <= in_data;
      frame_done_q <= frame_end;
      frame_err_q  <= frame_end & (geom_err != 2'b00);
      if (frame_end) begin
        err_status_q <= geom_err;
        frame_cnt_q  <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign out_vsync  = out_vsync_q;
  assign out_href   = out_href_q;
  assign out_clken  = out_clken_q;
  assign out_data   = out_data_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_status = err_status_q;
  assign frame_cnt  = frame_cnt_q;

endmodule : frame_gate_ctrl
`default_nettype wire

// File: tb/tb_frame_gate_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_frame_gate_ctrl
//  Purpose  : Directed self-checking bench for frame_gate_ctrl using a
//             16x8 source frame model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_gate_ctrl;

  localparam int HD = 16;
  localparam int VD = 8;
  localparam int DW = 24;
  // vsync-high cycles of a clean frame: 2 porch + VD*(2*HD + 3) + 2 porch
  localparam int VS_HI = 2 + VD * (2 * HD + 3) + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_start, cmd_stop, cfg_single;
  logic [3:0]    cfg_skip;
  logic          in_vsync, in_href, in_clken;
  logic [DW-1:0] in_data;
  logic          out_vsync, out_href, out_clken;
  logic [DW-1:0] out_data;
  logic          busy, frame_done, frame_err;
  logic [1:0]    err_status;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  frame_gate_ctrl #(
    .IMG_HDISP (HD),
    .IMG_VDISP (VD),
    .DATA_W    (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_start  (cmd_start),
    .cmd_stop   (cmd_stop),
    .cfg_single (cfg_single),
    .cfg_skip   (cfg_skip),
    .in_vsync   (in_vsync),
    .in_href    (in_href),
    .in_clken   (in_clken),
    .in_data    (in_data),
    .out_vsync  (out_vsync),
    .out_href   (out_href),
    .out_clken  (out_clken),
    .out_data   (out_data),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_status (err_status),
    .frame_cnt  (frame_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Cumulative output monitor; tests look at deltas.
  int m_clken = 0, m_vshi = 0, m_done = 0, m_err = 0, m_lat = 0, m_err_nodone = 0;
  logic          p_vs = 1'b0, p_href = 1'b0, p_clken = 1'b0, p_rst = 1'b0;
  logic [DW-1:0] p_data = '0;

  always @(negedge clk) begin
    if (out_clken === 1'b1)  m_clken++;
    if (out_vsync === 1'b1)  m_vshi++;
    if (frame_done === 1'b1) m_done++;
    if (frame_err === 1'b1)  m_err++;
    if (frame_err === 1'b1 && frame_done !== 1'b1) m_err_nodone++;
    // Outputs this cycle must reflect inputs snapshotted one cycle earlier.
    if (p_rst === 1'b1) begin
      if (out_data !== p_data) m_lat++;
      if (out_vsync === 1'b1 && p_vs !== 1'b1) m_lat++;
      if (out_href === 1'b1 && p_href !== 1'b1) m_lat++;
      if (out_clken === 1'b1 && !(p_clken === 1'b1 && p_href === 1'b1)) m_lat++;
    end
    p_vs    = in_vsync;
    p_href  = in_href;
    p_clken = in_clken;
    p_data  = in_data;
    p_rst   = rst_n;
  end

  logic [DW-1:0] pix_val = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int npix);
    for (int i = 0; i < 2 * npix; i++) begin
      in_href  = 1'b1;
      in_clken = (i % 2 == 1);
      in_data  = pix_val;
      pix_val  = pix_val + 1'b1;
      step();
    end
    in_href  = 1'b0;
    in_clken = 1'b0;
    repeat (3) step();
  endtask

  task automatic send_frame(input int lines, input int short_line);
    in_vsync = 1'b1;
    repeat (2) step();
    for (int l = 0; l < lines; l++) send_line((l == short_line) ? HD - 1 : HD);
    repeat (2) step();
    in_vsync = 1'b0;
    repeat (4) step();
  endtask

  task automatic pulse_cmd(input logic s, input logic p);
    cmd_start = s;
    cmd_stop  = p;
    step();
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (out_vsync !== 1'b0) $display("FAIL reset_out_vsync: got %b want 0", out_vsync); else n_pass++;
    n_total++; if (out_clken !== 1'b0) $display("FAIL reset_out_clken: got %b want 0", out_clken); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
    n_total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else n_pass++;
    n_total++; if (err_status !== 2'b00) $display("FAIL reset_err_status: got %b want 00", err_status); else n_pass++;
    n_total++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int c0, v0, d0, e0, l0;
    apply_reset();
    cfg_single = 1'b1;
    cfg_skip   = 4'd0;
    c0 = m_clken;
    fork
      send_frame(VD, -1);
      begin repeat (60) step(); pulse_cmd(1'b1, 1'b0); end
    join
    n_total++; if (m_clken - c0 != 0) $display("FAIL single_partial_blocked: got %0d clken want 0", m_clken - c0); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL single_armed_busy: got %b want 1", busy); else n_pass++;
    c0 = m_clken; v0 = m_vshi; d0 = m_done; e0 = m_err; l0 = m_lat;
    send_frame(VD, -1);
    n_total++; if (m_clken - c0 != 128) $display("FAIL single_clken: got %0d want 128", m_clken - c0); else n_pass++;
    n_total++; if (m_vshi - v0 != VS_HI) $display("FAIL single_vsync_window: got %0d want %0d", m_vshi - v0, VS_HI); else n_pass++;
    n_total++; if (m_done - d0 != 1) $display("FAIL single_done: got %0d want 1", m_done - d0); else n_pass++;
    n_total++; if (m_err - e0 != 0) $display("FAIL single_err: got %0d want 0", m_err - e0); else n_pass++;
    n_total++; if (m_lat - l0 != 0) $display("FAIL single_latency: got %0d violations want 0", m_lat - l0); else n_pass++;
    n_total++; if (frame_cnt !== 16'd1) $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt); else n_pass++;
    n_total++; if (err_status !== 2'b00) $display("FAIL single_err_status: got %b want 00", err_status); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_idle_after: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_decimation();
    int c0, exp_c;
    apply_reset();
    cfg_single = 1'b0;
    cfg_skip   = 4'd2;
    pulse_cmd(1'b1, 1'b0);
    for (int f = 1; f <= 9; f++) begin
      c0 = m_clken;
      send_frame(VD, -1);
      exp_c = (f % 3 == 0) ? 128 : 0;
      n_total++; if (m_clken - c0 != exp_c) $display("FAIL decim_frame%0d: got %0d clken want %0d", f, m_clken - c0, exp_c); else n_pass++;
    end
    n_total++; if (frame_cnt !== 16'd3) $display("FAIL decim_frame_cnt: got %0d want 3", frame_cnt); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL decim_busy: got %b want 1", busy); else n_pass++;
    pulse_cmd(1'b0, 1'b1);
    n_total++; if (busy !== 1'b0) $display("FAIL decim_stop_in_arm: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_stop_mid();
    int c0, v0, d0;
    apply_reset();
    cfg_single = 1'b0;
    cfg_skip   = 4'd0;
    pulse_cmd(1'b1, 1'b0);
    c0 = m_clken; d0 = m_done;
    fork
      send_frame(VD, -1);
      begin repeat (2 + 3 * (2 * HD + 3) + 10) step(); pulse_cmd(1'b0, 1'b1); end
    join
    n_total++; if (m_clken - c0 != 128) $display("FAIL stop_frame_completes: got %0d clken want 128", m_clken - c0); else n_pass++;
    n_total++; if (m_done - d0 != 1) $display("FAIL stop_done: got %0d want 1", m_done - d0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL stop_idle: got %b want 0", busy); else n_pass++;
    c0 = m_clken; v0 = m_vshi;
    send_frame(VD, -1);
    send_frame(VD, -1);
    n_total++; if (m_clken - c0 != 0) $display("FAIL stop_blocked_clken: got %0d want 0", m_clken - c0); else n_pass++;
    n_total++; if (m_vshi - v0 != 0) $display("FAIL stop_blocked_vsync: got %0d want 0", m_vshi - v0); else n_pass++;
    n_total++; if (frame_cnt !== 16'd1) $display("FAIL stop_frame_cnt: got %0d want 1", frame_cnt); else n_pass++;
  endtask

  task automatic test_geom_err();
    int e0, d0, n0;
    apply_reset();
    cfg_single = 1'b0;
    cfg_skip   = 4'd0;
    pulse_cmd(1'b1, 1'b0);
    n0 = m_err_nodone;
    e0 = m_err; d0 = m_done;
    send_frame(VD, 2);
    n_total++; if (err_status !== 2'b01) $display("FAIL geom_short_line_status: got %b want 01", err_status); else n_pass++;
    n_total++; if (m_err - e0 != 1) $display("FAIL geom_short_line_pulse: got %0d want 1", m_err - e0); else n_pass++;
    e0 = m_err;
    send_frame(VD - 1, -1);
    n_total++; if (err_status !== 2'b10) $display("FAIL geom_short_frame_status: got %b want 10", err_status); else n_pass++;
    n_total++; if (m_err - e0 != 1) $display("FAIL geom_short_frame_pulse: got %0d want 1", m_err - e0); else n_pass++;
    e0 = m_err;
    send_frame(VD, -1);
    n_total++; if (err_status !== 2'b00) $display("FAIL geom_clean_status: got %b want 00", err_status); else n_pass++;
    n_total++; if (m_err - e0 != 0) $display("FAIL geom_clean_pulse: got %0d want 0", m_err - e0); else n_pass++;
    n_total++; if (m_done - d0 != 3) $display("FAIL geom_done_count: got %0d want 3", m_done - d0); else n_pass++;
    n_total++; if (m_err_nodone - n0 != 0) $display("FAIL geom_err_with_done: got %0d stray want 0", m_err_nodone - n0); else n_pass++;
    n_total++; if (frame_cnt !== 16'd3) $display("FAIL geom_frame_cnt: got %0d want 3", frame_cnt); else n_pass++;
  endtask

  task automatic test_start_stop();
    int c0;
    apply_reset();
    cfg_single = 1'b0;
    cfg_skip   = 4'd0;
    pulse_cmd(1'b1, 1'b1);
    n_total++; if (busy !== 1'b0) $display("FAIL startstop_stays_idle: got %b want 0", busy); else n_pass++;
    c0 = m_clken;
    send_frame(VD, -1);
    n_total++; if (m_clken - c0 != 0) $display("FAIL startstop_no_capture: got %0d want 0", m_clken - c0); else n_pass++;
    cfg_single = 1'b1;
    cfg_skip   = 4'd1;
    pulse_cmd(1'b1, 1'b0);
    n_total++; if (busy !== 1'b1) $display("FAIL startstop_armed: got %b want 1", busy); else n_pass++;
    // Re-issuing start in ARM with different config must not reload it.
    cfg_single = 1'b0;
    cfg_skip   = 4'd0;
    pulse_cmd(1'b1, 1'b0);
    c0 = m_clken;
    send_frame(VD, -1);
    n_total++; if (m_clken - c0 != 0) $display("FAIL startstop_arm_skip_kept: got %0d want 0", m_clken - c0); else n_pass++;
    c0 = m_clken;
    fork
      send_frame(VD, -1);
      begin repeat (50) step(); pulse_cmd(1'b1, 1'b0); end
    join
    n_total++; if (m_clken - c0 != 128) $display("FAIL startstop_capture: got %0d want 128", m_clken - c0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL startstop_single_kept: got %b want 0", busy); else n_pass++;
    n_total++; if (frame_cnt !== 16'd1) $display("FAIL startstop_frame_cnt: got %0d want 1", frame_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c0, d0;
    apply_reset();
    cfg_single = 1'b1;
    cfg_skip   = 4'd0;
    pulse_cmd(1'b1, 1'b0);
    fork
      send_frame(VD, -1);
      begin
        repeat (2 + 3 * (2 * HD + 3) + 10) step();
        n_total++; if (out_vsync !== 1'b1) $display("FAIL rstmid_pre_vsync: got %b want 1", out_vsync); else n_pass++;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_total++; if (out_vsync !== 1'b0) $display("FAIL rstmid_vsync: got %b want 0", out_vsync); else n_pass++;
        n_total++; if (out_href !== 1'b0) $display("FAIL rstmid_href: got %b want 0", out_href); else n_pass++;
        n_total++; if (out_clken !== 1'b0) $display("FAIL rstmid_clken: got %b want 0", out_clken); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL rstmid_data: got %h want 0", out_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        rst_n = 1'b1;
      end
    join
    n_total++; if (frame_cnt !== 16'd0) $display("FAIL rstmid_frame_cnt: got %0d want 0", frame_cnt); else n_pass++;
    pulse_cmd(1'b1, 1'b0);
    c0 = m_clken; d0 = m_done;
    send_frame(VD, -1);
    n_total++; if (m_clken - c0 != 128) $display("FAIL rstmid_recapture: got %0d want 128", m_clken - c0); else n_pass++;
    n_total++; if (m_done - d0 != 1) $display("FAIL rstmid_done: got %0d want 1", m_done - d0); else n_pass++;
    n_total++; if (frame_cnt !== 16'd1) $display("FAIL rstmid_frame_cnt_after: got %0d want 1", frame_cnt); else n_pass++;
    n_total++; if (err_status !== 2'b00) $display("FAIL rstmid_err_status: got %b want 00", err_status); else n_pass++;
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_start  = 1'b0;
    cmd_stop   = 1'b0;
    cfg_single = 1'b0;
    cfg_skip   = 4'd0;
    in_vsync   = 1'b0;
    in_href    = 1'b0;
    in_clken   = 1'b0;
    in_data    = '0;
    test_reset();
    test_single();
    test_decimation();
    test_stop_mid();
    test_geom_err();
    test_start_stop();
    test_reset_mid();
    n_total++; if (m_lat != 0) $display("FAIL latency_overall: got %0d violations want 0", m_lat); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_frame_gate_ctrl
`default_nettype wire

// File: doc/frame_gate_ctrl.md
Name: frame_gate_ctrl

Overview:
- Sits between the CMOS-style pixel source and the processing pipeline.
- Accepts software-style commands (start, stop, single or continuous mode, frame decimation) and passes only whole, selected frames downstream.
- Counts pixels per line and lines per frame, and flags frames whose geometry differs from IMG_HDISP x IMG_VDISP.
- Stream convention: vsync low = sync, high = frame valid; pixel qualified by href & clken.

Parameters:
- IMG_HDISP, 640, expected pixels per line (count of clken pulses while href high).
- IMG_VDISP, 480, expected lines per frame (count of href falling edges while vsync high).
- DATA_W, 24, pixel width (RGB888).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous active-low reset.
- cmd_start  in  1  one-cycle pulse: arm capture.
- cmd_stop  in  1  one-cycle pulse: stop capture.
- cfg_single  in  1  1 = capture one frame then idle; 0 = continuous.
- cfg_skip  in  4  frames dropped before each captured frame (0 = none).
- in_vsync  in  1  source vsync.
- in_href  in  1  source href.
- in_clken  in  1  source pixel enable.
- in_data  in  DATA_W  source pixel.
- out_vsync  out  1  gated vsync.
- out_href  out  1  gated href.
- out_clken  out  1  gated pixel enable.
- out_data  out  DATA_W  pixel, registered.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse at end of each captured frame.
- frame_err  out  1  one-cycle pulse, coincident with frame_done, when the frame geometry is wrong.
- err_status  out  2  bit0 = line-length error, bit1 = line-count error; holds the last captured frame's status.
- frame_cnt  out  16  captured frames; wraps from 0xFFFF to 0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - All outputs and counters go to 0.
  - Applies mid-frame too; downstream sees the stream drop on the next edge.
- Edge detection:
  - vs_d is registered in_vsync; vs_rise = in_vsync & ~vs_d; vs_fall = ~in_vsync & vs_d.
  - href_fall is derived the same way.
- States: IDLE, ARM, ACTIVE.
- IDLE:
  - cmd_start loads skip_cnt = cfg_skip and latches cfg_single, then goes to ARM.
  - cmd_stop is a no-op. If cmd_start and cmd_stop are both asserted, stop wins and the block stays IDLE.
- ARM:
  - Waits for vs_rise. A partial frame already in progress is never captured.
  - On vs_rise: if skip_cnt == 0, go to ACTIVE; otherwise decrement skip_cnt and stay in ARM, dropping that frame.
  - cmd_stop goes to IDLE immediately. cmd_start is ignored.
- ACTIVE:
  - Stream passes through. Counters clear on entry.
  - cmd_stop sets stop_pend; the current frame always completes. cmd_start is ignored.
  - On vs_fall (end of frame):
    - pulse frame_done;
    - update err_status and pulse frame_err if it is nonzero;
    - increment frame_cnt.
  - Next state after vs_fall: IDLE if single mode or stop_pend (stop_pend clears). Otherwise ARM, with skip_cnt reloaded from the live cfg_skip.
- Gating:
  - pass = (state == ACTIVE) | (state == ARM & vs_rise & skip_cnt == 0).
  - On each edge: out_vsync <= pass & in_vsync, out_href <= pass & in_href, out_clken <= pass & in_clken, out_data <= in_data.
  - Fixed latency of 1 cycle for all four signals.
  - A captured frame therefore appears downstream as a complete vsync-high window.
- Geometry check (ACTIVE only):
  - pix_cnt increments on in_href & in_clken.
  - On href_fall: flag bit0 if pix_cnt != IMG_HDISP; clear pix_cnt; increment line_cnt.
  - On vs_fall: flag bit1 if line_cnt != IMG_VDISP.
  - If href falls in the same cycle as vsync, that line is counted before the check.
  - Both counters saturate at all-ones, so an overlong frame can never wrap into a false pass.
  - Sticky flags clear on entry to ACTIVE.

Decomposition:
- Package frame_gate_pkg:
  - state enum (IDLE, ARM, ACTIVE);
  - ERR_LINE_LEN = 0, ERR_LINE_CNT = 1;
  - counter width function ($clog2 of max(IMG_HDISP, IMG_VDISP) + 1).
- Sub-module frame_geom_checker:
  - contains the edge detect, pix/line counters and sticky flags;
  - inputs: enable, clear, href, clken, vsync;
  - outputs: err[1:0].
- Top level holds the FSM, skip counter, gating registers and frame_cnt.

Test Plan:
All scenarios use a source model with IMG_HDISP=16, IMG_VDISP=8; the DUT uses the same values.
- Single capture: cmd_start with cfg_single=1, cfg_skip=0, applied mid-frame → partial frame blocked; next frame passes with 128 out_clken pulses and 1-cycle latency; frame_done once, frame_err=0, frame_cnt=1, busy then falls.
- Decimation: continuous mode, cfg_skip=2, 9 source frames → frames 3, 6 and 9 pass; frame_cnt=3; no out_clken during skipped frames.
- Stop mid-frame: cmd_stop in line 4 of an ACTIVE frame → that frame completes with all 128 pixels, frame_done, then IDLE; following frames fully blocked.
- Geometry error: source emits one 15-pixel line, then a frame of 7 lines → first frame err_status=01 with frame_err pulse; second frame err_status=10 (bit0 clear); a clean third frame gives 00.
- Simultaneous start+stop in IDLE → stays IDLE, busy=0; start alone while ARM/ACTIVE → no state change.
- Reset mid-frame (synchronous rst_n low for 1 cycle) → all outputs 0 on the next edge, IDLE, frame_cnt=0; re-arm captures the next complete frame correctly.
